// File: rtl/std_fp_smult_share_pkg.sv
// rtl/std_fp_smult_share_pkg.sv - shared helpers for the fixed-point multiplier share
package fp_share_pkg;

    // Tag width for an N-requester share; never narrower than one bit.
    function automatic int tag_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Low bit of slice idx in a flattened bus of w-bit lanes.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/std_fp_smult_share_if.sv
// rtl/std_fp_smult_share_if.sv - go/done request bundle between requesters and the shared multiplier
interface std_fp_smult_share_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       go;
    logic [NREQ*WIDTH-1:0] left;
    logic [NREQ*WIDTH-1:0] right;
    logic [NREQ*WIDTH-1:0] out;
    logic [NREQ-1:0]       done;

    modport master (output go, left, right, input out, done);
    modport slave  (input go, left, right, output out, done);
endinterface

// File: rtl/std_fp_smult_share_rr_arbiter.sv
// rtl/std_fp_smult_share_rr_arbiter.sv - round-robin single-grant arbiter owning the priority pointer
module std_rr_arbiter
    import fp_share_pkg::*;
#(
    parameter int N = 4,
    localparam int TW = tag_w(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic          grant_valid,
    output logic [TW-1:0] grant_idx
);
    logic [TW-1:0] ptr_q, ptr_d;

    // Scan from the far end back toward ptr so the index closest to ptr wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx[TW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = TW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/std_fp_smult_share.sv
// rtl/std_fp_smult_share.sv - one pipelined signed fixed-point multiplier shared by NREQ go/done requesters
module std_fp_smult_share
    import fp_share_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 24,
    parameter int NREQ        = 4,
    parameter int LATENCY     = 2
) (
    input logic clk,
    input logic reset,
    std_fp_smult_share_if.slave bus
);
    localparam int TW = tag_w(NREQ);

    if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_bad_split
        $error("INT_WIDTH + FRACT_WIDTH must equal WIDTH");
    end

    logic [NREQ-1:0]         eligible, inflight_q, inflight_d, done_w;
    logic                    grant_valid;
    logic [TW-1:0]           grant_idx;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]        res;
    logic [WIDTH-1:0]        data_q [LATENCY];
    logic [TW-1:0]           tag_q  [LATENCY];
    logic [LATENCY-1:0]      valid_q;
    logic [WIDTH-1:0]        hold_q [NREQ];

    assign eligible = bus.go & ~inflight_q & ~done_w;

    std_rr_arbiter #(.N(NREQ)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (eligible),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == TW'(i)) begin
                a_s = bus.left[slice_lo(i, WIDTH) +: WIDTH];
                b_s = bus.right[slice_lo(i, WIDTH) +: WIDTH];
            end
        end
        prod = a_s * b_s;
        // Arithmetic shift then truncate: floors toward -inf and wraps integer overflow.
        res  = WIDTH'(prod >>> FRACT_WIDTH);
    end

    always_comb begin
        done_w = '0;
        for (int i = 0; i < NREQ; i++)
            done_w[i] = valid_q[LATENCY-1] && (tag_q[LATENCY-1] == TW'(i));
    end

    always_comb begin
        inflight_d = inflight_q;
        if (valid_q[LATENCY-1]) inflight_d[tag_q[LATENCY-1]] = 1'b0;
        if (grant_valid)        inflight_d[grant_idx]        = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            inflight_q <= '0;
            for (int l = 0; l < LATENCY; l++) begin
                data_q[l] <= '0;
                tag_q[l]  <= '0;
            end
            for (int i = 0; i < NREQ; i++) hold_q[i] <= '0;
        end else begin
            valid_q[0] <= grant_valid;
            data_q[0]  <= res;
            tag_q[0]   <= grant_idx;
            for (int l = 1; l < LATENCY; l++) begin
                valid_q[l] <= valid_q[l-1];
                data_q[l]  <= data_q[l-1];
                tag_q[l]   <= tag_q[l-1];
            end
            inflight_q <= inflight_d;
            if (valid_q[LATENCY-1]) hold_q[tag_q[LATENCY-1]] <= data_q[LATENCY-1];
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_out
        assign bus.out[slice_lo(i, WIDTH) +: WIDTH] = done_w[i] ? data_q[LATENCY-1] : hold_q[i];
    end
    assign bus.done = done_w;
endmodule
